// File: rtl/str_pkg.sv
// Shared types and constants for the framed-string transmitter (str_tx) and its LFSR.
// The optional error-injection feature is enabled by defining STR_TX_ERR_INJECT_EN.
package str_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_HEAD,
    S_BODY,
    S_EOF,
    S_DONE
  } state_t;

  localparam logic [7:0] NUL    = 8'h00;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] CHAR_0 = 8'h30;
  localparam logic [7:0] CHAR_A = 8'h41;

  // Finance-start header characters: '#', '$', '%', '&', '@'
  localparam int         FIN_N = 5;
  localparam logic [7:0] FIN_TABLE [FIN_N] = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h40};

  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] fin_head(input logic [7:0] seed);
    logic [7:0] idx;
    idx = seed % 8'd5;
    case (idx)
      8'd0:    return FIN_TABLE[0];
      8'd1:    return FIN_TABLE[1];
      8'd2:    return FIN_TABLE[2];
      8'd3:    return FIN_TABLE[3];
      default: return FIN_TABLE[4];
    endcase
  endfunction

  // Even LFSR value selects a digit, odd selects an upper-case letter.
  function automatic logic [7:0] body_char(input logic [7:0] l);
    logic [6:0] h;
    h = l[7:1];
    if (!l[0]) return CHAR_0 + 8'(h % 7'd10);
    else       return CHAR_A + 8'(h % 7'd26);
  endfunction

endpackage

// File: rtl/str_tx_if.sv
// Valid/ready byte stream between the string transmitter and its checker.
interface str_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/str_lfsr.sv
// 8-bit Fibonacci LFSR used to pick body characters; a zero seed is replaced by 0x01.
module str_lfsr
  import str_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst)       value <= 8'h01;
    else if (load) value <= (seed == 8'h00) ? 8'h01 : seed;
    else if (step) value <= {value[6:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/str_tx.sv
// Framed string transmitter: emits NUL, HEAD, BODY[len], NUL over a valid/ready stream.
// Define STR_TX_ERR_INJECT_EN to add the inj_err port that corrupts the last body byte.
module str_tx
  import str_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] len,
  input  logic [7:0] seed,
`ifdef STR_TX_ERR_INJECT_EN
  input  logic       inj_err,
`endif
  output logic       busy,
  output logic       done,
  str_tx_if.master   tx
);

  state_t     state_q, state_d;
  logic [3:0] len_q, cnt_q;
  logic [7:0] head_q;
  logic       inj_q, inj_in;
  logic       lfsr_load, lfsr_step;
  logic [7:0] lfsr_val;
  logic       xfer, last_body;

`ifdef STR_TX_ERR_INJECT_EN
  assign inj_in = inj_err;
`else
  assign inj_in = 1'b0;
`endif

  assign xfer      = tx.valid && tx.ready;
  assign last_body = (cnt_q == len_q - 4'd1);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      head_q  <= NUL;
      inj_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (lfsr_load) begin
        len_q  <= len;
        cnt_q  <= 4'd0;
        head_q <= fin_head(seed);
        inj_q  <= inj_in;
      end else if (state_q == S_BODY && xfer) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    tx.valid  = 1'b0;
    tx.data   = NUL;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          state_d   = S_SOF;
        end
      end
      S_SOF: begin
        tx.valid = 1'b1;
        if (tx.ready) state_d = S_HEAD;
      end
      S_HEAD: begin
        tx.valid = 1'b1;
        tx.data  = (inj_q && len_q == 4'd0) ? DOT : head_q;
        if (tx.ready) state_d = (len_q == 4'd0) ? S_EOF : S_BODY;
      end
      S_BODY: begin
        tx.valid = 1'b1;
        tx.data  = (inj_q && last_body) ? DOT : body_char(lfsr_val);
        if (tx.ready) begin
          lfsr_step = 1'b1;
          if (last_body) state_d = S_EOF;
        end
      end
      S_EOF: begin
        tx.valid = 1'b1;
        if (tx.ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  str_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .step (lfsr_step),
    .value(lfsr_val)
  );

endmodule

// File: tb/tb_str_tx.sv
// Self-checking bench for str_tx: directed frames plus randomized frames and back-pressure
// compared against a byte-list reference model.
module tb_str_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic [7:0] seed;
  logic       busy, done;
`ifdef STR_TX_ERR_INJECT_EN
  logic       inj_err;
`endif

  str_tx_if tx ();

  str_tx dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .len    (len),
    .seed   (seed),
`ifdef STR_TX_ERR_INJECT_EN
    .inj_err(inj_err),
`endif
    .busy   (busy),
    .done   (done),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit cur_inj;
  localparam logic [7:0] HEADS [5] = '{8'h23, 8'h24, 8'h25, 8'h26, 8'h40};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Checker side: ready is applied a little after each rising edge.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       tx.ready = 1'b1;
      1:       tx.ready = 1'($urandom_range(0, 1));
      default: tx.ready = 1'b0;
    endcase
  end

  // Monitor: log accepted bytes, and require an offered byte to stay put until taken.
  logic       stall_q = 1'b0;
  logic [7:0] stall_d = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(tx.valid), 32'd1);
        check("hold_data", 32'(tx.data), 32'(stall_d));
      end
      if (tx.valid && tx.ready) got.push_back(tx.data);
      stall_q = tx.valid && !tx.ready;
      stall_d = tx.data;
    end
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    int v, fb;
    v  = int'(l);
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return 8'(((v << 1) | fb) & 255);
  endfunction

  function automatic bit is_char(input logic [7:0] c);
    return (c >= 8'd48 && c <= 8'd57) || (c >= 8'd65 && c <= 8'd90);
  endfunction

  task automatic build_exp(input int l, input int s, input bit inj);
    int v, c;
    exp_q.delete();
    v = (s == 0) ? 1 : s;
    exp_q.push_back(8'h00);
    exp_q.push_back((inj && l == 0) ? 8'h2E : HEADS[s % 5]);
    for (int i = 0; i < l; i++) begin
      if (v % 2 == 0) c = 48 + (v / 2) % 10;
      else            c = 65 + (v / 2) % 26;
      if (inj && i == l - 1) c = 46;
      exp_q.push_back(8'(c));
      v = int'(lfsr_next(8'(v)));
    end
    exp_q.push_back(8'h00);
  endtask

  task automatic start_frame(input int l, input int s, input bit inj);
    build_exp(l, s, inj);
    cur_inj = inj;
    @(posedge clk);
    #1;
    got.delete();
    start = 1'b1;
    len   = 4'(l);
    seed  = 8'(s);
`ifdef STR_TX_ERR_INJECT_EN
    inj_err = inj;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    check("lat_valid", 32'(tx.valid), 32'd1);
    check("lat_data", 32'(tx.data), 32'h00);
    check("lat_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_frame(input bit spam);
    int n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (spam && !done) begin
        start = 1'($urandom_range(0, 1));
        len   = 4'($urandom);
        seed  = 8'($urandom);
      end
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_valid", 32'(tx.valid), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    start = spam;  // start coincident with DONE must be ignored
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(tx.valid), 32'd0);
    @(posedge clk);
    #1;
    check("idle_valid2", 32'(tx.valid), 32'd0);
    check("idle_busy2", 32'(busy), 32'd0);
    check("nbytes", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    for (int i = 2; i < got.size() - 1; i++)
      if (!(cur_inj && i == got.size() - 2))
        check($sformatf("class%0d", i), 32'(is_char(got[i])), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] held;
    int         n;
    rst   = 1'b1;
    start = 1'b0;
    len   = 4'd0;
    seed  = 8'd0;
`ifdef STR_TX_ERR_INJECT_EN
    inj_err = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(tx.valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(tx.data), 32'h00);
    rst = 1'b0;
    got.delete();
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_xfer", 32'(got.size()), 32'd0);

    // Shortest frame, cycle-exact
    start_frame(0, 8'h01, 1'b0);
    @(posedge clk); #1;
    check("short_head", 32'(tx.data), 32'h24);
    check("short_head_v", 32'(tx.valid), 32'd1);
    @(posedge clk); #1;
    check("short_eof", 32'(tx.data), 32'h00);
    check("short_eof_v", 32'(tx.valid), 32'd1);
    @(posedge clk); #1;
    check("short_done", 32'(done), 32'd1);
    finish_frame(1'b0);

    // Seed 3, four body characters
    start_frame(4, 8'h03, 1'b0);
    finish_frame(1'b0);
    check("seed3_head", 32'(got.size() > 1 ? got[1] : 8'h00), 32'h26);

    // Back-pressure during BODY
    start_frame(6, 8'h5A, 1'b0);
    n = 0;
    while (got.size() < 3 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("stall_reach", 32'(got.size() >= 3), 32'd1);
    ready_mode = 2;
    held = tx.data;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_v", 32'(tx.valid), 32'd1);
      check("stall_d", 32'(tx.data), 32'(held));
    end
    ready_mode = 0;
    finish_frame(1'b0);

    // start pulsed throughout a frame and on its DONE cycle
    start_frame(5, int'($urandom_range(0, 255)), 1'b0);
    finish_frame(1'b1);

    // Reset while the second body byte is offered
    start_frame(5, 8'hC3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_v", 32'(tx.valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 32'(tx.valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    start_frame(3, 8'hC3, 1'b0);
    finish_frame(1'b0);

    // Randomized frames with random back-pressure
    ready_mode = 1;
    for (int f = 0; f < 16; f++) begin
      int l, s;
      l = (f == 0) ? 15 : int'($urandom_range(0, 15));
      s = (f == 1) ? 0 : int'($urandom_range(0, 255));
      start_frame(l, s, 1'b0);
      finish_frame(f % 4 == 3);
    end
    ready_mode = 0;

`ifdef STR_TX_ERR_INJECT_EN
    start_frame(3, 8'h77, 1'b1);
    finish_frame(1'b0);
    check("inj_dot", 32'(got.size() > 4 ? got[4] : 8'h00), 32'h2E);
    start_frame(0, 8'h12, 1'b1);
    finish_frame(1'b0);
    check("inj_head", 32'(got.size() > 1 ? got[1] : 8'h00), 32'h2E);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/str_tx.md
STR_TX -- requirements
Module: str_tx

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request one framed string; sampled only in IDLE.
REQ-004 SHALL have port len, input, 4 bits: body character count, 0..15; sampled with start.
REQ-005 SHALL have port seed, input, 8 bits: character selection seed; sampled with start.
REQ-006 SHALL have port data, output, 8 bits: ASCII byte offered to the checker.
REQ-007 SHALL have port valid, output, 1 bit: data is valid.
REQ-008 SHALL have port ready, input, 1 bit: the checker accepts data.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-011 SHALL generate frame NUL(0x00), HEAD, BODY[len], NUL(0x00), matching the checker's finance-start pattern.
REQ-012 SHALL use FSM states IDLE -> SOF -> HEAD -> BODY -> EOF -> DONE -> IDLE; len=0 skips BODY, HEAD -> EOF.
REQ-013 SHALL complete a transfer only when valid && ready are both high in the same cycle; the FSM advances only on a transfer.
REQ-014 SHALL hold data stable and valid high until transfer; valid SHALL never drop without a transfer.
REQ-015 SHALL have latency: start=1 in IDLE at cycle N -> valid=1, data=0x00 at cycle N+1.
REQ-016 SHALL choose HEAD from table {'#','$','%','&','@'} at index seed mod 5.
REQ-017 SHALL load an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with seed at start; seed 0x00 loads 0x01.
REQ-018 SHALL build each BODY byte from the current LFSR value L: L[0]=0 -> '0'+(L[7:1] mod 10), else 'A'+(L[7:1] mod 26).
REQ-019 SHALL advance the LFSR once per BODY transfer.
REQ-020 SHALL use a 4-bit body counter: cleared at start, +1 per BODY transfer, BODY -> EOF when counter == len-1 transfers.
REQ-021 SHALL set busy=1 from cycle N+1 through the DONE cycle.
REQ-022 SHALL pulse done=1 for exactly one cycle, the cycle after the final NUL transfer; valid=0 in DONE.
REQ-023 SHALL ignore start while busy; start coincident with DONE SHALL be ignored.
REQ-024 SHALL not require ready to be high ahead of valid; ready without valid has no effect.

Reset
REQ-025 SHALL force on rst: state=IDLE, data=0x00, valid=0, busy=0, done=0, counter=0, LFSR=0x01.
REQ-026 SHALL abort the frame on rst mid-frame with no closing NUL; the next frame starts clean.
REQ-027 SHALL give rst priority over start and over a transfer in the same cycle.

Configuration
REQ-028 SHALL add input port inj_err (1 bit, sampled with start) when macro STR_TX_ERR_INJECT_EN is defined.
REQ-029 SHALL, with the macro defined and inj_err=1, replace the last BODY byte with '.' (0x2E), or HEAD when len=0, so the checker reports ERROR.
REQ-030 SHALL, without the macro, have no inj_err port and always produce well-formed frames.

Structure
REQ-031 SHALL place these in shared package str_pkg: FSM state typedef; constants NUL, DOT, CHAR_0, CHAR_A; the finance table; LFSR tap mask.
REQ-032 SHALL implement the LFSR in sub-module str_lfsr (ports clk, rst, load, seed, step, value).

Verification
REQ-033 SHALL check: seed=0x01, len=0, ready=1 -> bytes 00, 24, 00 on consecutive cycles; done at the 4th cycle after start.
REQ-034 SHALL check: seed=0x03, len=4 -> HEAD '&' (0x26), 4 bytes in '0'..'9'/'A'..'Z', NUL; the byte stream matches the LFSR reference model.
REQ-035 SHALL check: ready=0 for 3 cycles during BODY -> data/valid held constant; no byte is lost or duplicated.
REQ-036 SHALL check: start pulsed while busy=1 -> ignored; exactly one frame is emitted.
REQ-037 SHALL check: rst asserted on the 2nd BODY byte -> valid=0, busy=0 next cycle; a new start emits a fresh frame beginning 0x00.
REQ-038 SHALL check, with STR_TX_ERR_INJECT_EN: len=3, inj_err=1 -> 3rd body byte 0x2E; the connected tsk checker reaches ERROR.
